// File: rtl/entry_alloc_table.sv
// Slot allocator: registered free bitmap, highest-index-first grant, release on free.
// Optional feature macro: ENTRY_ALLOC_CHECK_EN enables the sticky err_bad_free flag.
module entry_alloc_table #(
    parameter int  NUM_ENTRIES = 8,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   alloc_req,
    output logic                   alloc_valid,
    output logic [IDX_W-1:0]       alloc_index,
    input  logic                   free_valid,
    input  logic [IDX_W-1:0]       free_index,
    output logic [NUM_ENTRIES-1:0] free_bitmap,
    output logic [CNT_W-1:0]       used_count,
    output logic                   full,
    output logic                   empty,
    output logic                   err_bad_free
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e                 state_q;
    logic [NUM_ENTRIES-1:0] free_bitmap_q, free_bitmap_d;
    logic [CNT_W-1:0]       used_count_q, used_count_d;
    logic                   running;
    logic                   alloc_fire;
    logic                   free_in_range;
    logic                   free_eff;

    assign running = (state_q == ST_RUN);

    // NOTE: default assignment first so every path drives alloc_index and no latch is inferred.
    always_comb begin
        alloc_index = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (free_bitmap_q[i]) alloc_index = IDX_W'(i);
        end
    end

    assign alloc_valid   = running && (|free_bitmap_q);
    assign alloc_fire    = alloc_req && alloc_valid;
    assign free_in_range = (32'(free_index) < 32'(NUM_ENTRIES));
    assign free_eff      = free_valid && running && free_in_range && !free_bitmap_q[free_index];

    // A granted slot is used and a freed one is free, so the two indices never collide.
    always_comb begin
        free_bitmap_d = free_bitmap_q;
        if (alloc_fire) free_bitmap_d[alloc_index] = 1'b0;
        if (free_eff)   free_bitmap_d[free_index]  = 1'b1;
        used_count_d = used_count_q + CNT_W'(alloc_fire) - CNT_W'(free_eff);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            free_bitmap_q <= '1;
            used_count_q  <= '0;
        end else if (flush) begin
            state_q       <= ST_FLUSH;
            free_bitmap_q <= '1;
            used_count_q  <= '0;
        end else begin
            state_q       <= ST_RUN;
            free_bitmap_q <= free_bitmap_d;
            used_count_q  <= used_count_d;
        end
    end

`ifdef ENTRY_ALLOC_CHECK_EN
    logic err_q;
    logic free_bad;

    // Frees arriving during the flush cycle are dropped silently, not reported.
    assign free_bad = free_valid && running && !free_eff;

    always_ff @(posedge clk) begin
        if (rst || flush) err_q <= 1'b0;
        else if (free_bad) err_q <= 1'b1;
    end

    assign err_bad_free = err_q;
`else
    assign err_bad_free = 1'b0;
`endif

    assign free_bitmap = free_bitmap_q;
    assign used_count  = used_count_q;
    assign full        = (used_count_q == CNT_W'(NUM_ENTRIES));
    assign empty       = (used_count_q == '0);

endmodule
